// File: rtl/rggen_counter_pkg.sv
// rtl/rggen_counter_pkg.sv - shared types and flag positions for the event counter field
package rggen_counter_pkg;

  typedef enum logic {
    COUNTER_WRAP     = 1'b0,
    COUNTER_SATURATE = 1'b1
  } counter_mode_e;

  // Flag positions relative to WIDTH within the register field
  localparam int OVF_BIT = 0;
  localparam int UDF_BIT = 1;

endpackage

// File: rtl/rggen_bit_field_if.sv
// rtl/rggen_bit_field_if.sv - register-side access bundle for a single bit field
interface rggen_bit_field_if #(
  parameter int WIDTH = 32
);

  logic             valid;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] value;

  modport master (
    output valid,
    output write_data,
    output write_mask,
    input  read_data,
    input  value
  );

  modport bit_field (
    input  valid,
    input  write_data,
    input  write_mask,
    output read_data,
    output value
  );

endinterface

// File: rtl/rggen_popcount.sv
// rtl/rggen_popcount.sv - combinational ones-count of a bit vector
module rggen_popcount #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]               i_bits,
  output logic [$clog2(WIDTH+1)-1:0]     o_count
);

  localparam int OUT_W = $clog2(WIDTH + 1);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_count = o_count + OUT_W'(i_bits[i]);
    end
  end

endmodule

// File: rtl/rggen_bit_field_event_counter.sv
// rtl/rggen_bit_field_event_counter.sv - multi-channel up/down event counter bit field
module rggen_bit_field_event_counter
  import rggen_counter_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               CHANNELS      = 4,
  parameter counter_mode_e    MODE          = COUNTER_WRAP,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0,
  parameter logic [WIDTH-1:0] THRESHOLD     = '1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  rggen_bit_field_if.bit_field bit_field_if,
  input  logic                i_clear,
  input  logic [CHANNELS-1:0] i_up,
  input  logic [CHANNELS-1:0] i_down,
  output logic [WIDTH-1:0]    o_count,
  output logic                o_overflow,
  output logic                o_underflow,
  output logic                o_threshold_pulse
);

  localparam int PC_W  = $clog2(CHANNELS + 1);
  // Sum width covers the full count plus the largest possible delta, with sign
  localparam int SUM_W = ((WIDTH > PC_W) ? WIDTH : PC_W) + 2;
  localparam logic signed [SUM_W-1:0] MAX_COUNT =
    $signed({{(SUM_W-WIDTH){1'b0}}, {WIDTH{1'b1}}});

  logic [WIDTH-1:0]        count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    udf_q, udf_d;
  logic                    pulse_q, pulse_d;
  logic [PC_W-1:0]         up_cnt, down_cnt;
  logic signed [SUM_W-1:0] sum;
  logic                    sw_write;
  logic                    ovf_set, udf_set;
  logic                    ovf_clr, udf_clr;

  rggen_popcount #(.WIDTH(CHANNELS)) u_up_count (
    .i_bits  (i_up),
    .o_count (up_cnt)
  );

  rggen_popcount #(.WIDTH(CHANNELS)) u_down_count (
    .i_bits  (i_down),
    .o_count (down_cnt)
  );

  always_comb begin
    sum = $signed({{(SUM_W-WIDTH){1'b0}}, count_q})
        + $signed({{(SUM_W-PC_W){1'b0}}, up_cnt})
        - $signed({{(SUM_W-PC_W){1'b0}}, down_cnt});
  end

  assign sw_write = bit_field_if.valid && (|bit_field_if.write_mask[WIDTH-1:0]);
  assign ovf_clr  = bit_field_if.valid
                  && bit_field_if.write_mask[WIDTH+OVF_BIT]
                  && bit_field_if.write_data[WIDTH+OVF_BIT];
  assign udf_clr  = bit_field_if.valid
                  && bit_field_if.write_mask[WIDTH+UDF_BIT]
                  && bit_field_if.write_data[WIDTH+UDF_BIT];

  always_comb begin
    count_d = count_q;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (sw_write) begin
      count_d = (bit_field_if.write_data[WIDTH-1:0] & bit_field_if.write_mask[WIDTH-1:0])
              | (count_q & ~bit_field_if.write_mask[WIDTH-1:0]);
    end else if (i_clear) begin
      count_d = INITIAL_VALUE;
    end else if (sum[SUM_W-1]) begin
      udf_set = 1'b1;
      count_d = (MODE == COUNTER_WRAP) ? sum[WIDTH-1:0] : '0;
    end else if (sum > MAX_COUNT) begin
      ovf_set = 1'b1;
      count_d = (MODE == COUNTER_WRAP) ? sum[WIDTH-1:0] : '1;
    end else begin
      count_d = sum[WIDTH-1:0];
    end
  end

  // A concurrent set beats the write-1-to-clear
  assign ovf_d   = ovf_set || (ovf_q && !ovf_clr);
  assign udf_d   = udf_set || (udf_q && !udf_clr);
  assign pulse_d = (count_q < THRESHOLD) && (count_d >= THRESHOLD);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count_q <= INITIAL_VALUE;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      pulse_q <= pulse_d;
    end
  end

  assign o_count           = count_q;
  assign o_overflow        = ovf_q;
  assign o_underflow       = udf_q;
  assign o_threshold_pulse = pulse_q;

  assign bit_field_if.value     = {udf_q, ovf_q, count_q};
  assign bit_field_if.read_data = {udf_q, ovf_q, count_q};

endmodule

// File: doc/rggen_bit_field_event_counter.md
# rggen_bit_field_event_counter

Multi-channel event counter bit field for rggen register blocks; the next generation of the single up/down counter field. It accumulates up to CHANNELS up-events and CHANNELS down-events per cycle, wraps or saturates per MODE, and records sticky overflow/underflow flags that software clears by writing 1. It raises a threshold-crossing pulse. It sits behind a register via `rggen_bit_field_if` and drives a count output to user logic.

## Interface
- WIDTH, 8: counter width in bits (≥2).
- CHANNELS, 4: number of independent up and down event lines (≥1).
- MODE, COUNTER_WRAP: `counter_mode_e`, either COUNTER_WRAP or COUNTER_SATURATE.
- INITIAL_VALUE, '0: count value after reset and after clear; WIDTH bits.
- THRESHOLD, '1: crossing level for the pulse output; WIDTH bits, nonzero.
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- bit_field_if  modport bit_field  WIDTH+2  register access. Layout: [WIDTH-1:0] count, [WIDTH] overflow, [WIDTH+1] underflow.
- i_clear  in  1  restores the count to INITIAL_VALUE.
- i_up  in  CHANNELS  up events, each +1.
- i_down  in  CHANNELS  down events, each −1.
- o_count  out  WIDTH  registered count.
- o_overflow  out  1  sticky overflow flag.
- o_underflow  out  1  sticky underflow flag.
- o_threshold_pulse  out  1  one-cycle pulse on an upward crossing of THRESHOLD.

## Operation
- The reset is synchronous: a rising edge with i_rst_n=0 sets count=INITIAL_VALUE, both flags=0 and the pulse=0. No reset on i_rst_n negedge.
- Per-edge priority, highest first: reset > software write > i_clear > events.
- Software write: `valid && |write_mask[WIDTH-1:0]`.
  - count ← (write_data & mask) | (count & ~mask).
  - Events are dropped this cycle.
- Flag bits are W1C: a `valid` write with mask=1 and data=1 clears the flag.
  - If a set condition occurs in the same cycle, set wins.
  - Writing 0 to a flag has no effect.
- i_clear: count ← INITIAL_VALUE; events are dropped; flags are unchanged.
- Events: delta = popcount(i_up) − popcount(i_down). Evaluate sum = count + delta at WIDTH+2 signed width.
  - sum > 2^WIDTH−1: set overflow. WRAP gives sum mod 2^WIDTH; SATURATE gives all-ones.
  - sum < 0: set underflow. WRAP gives sum mod 2^WIDTH; SATURATE gives 0.
  - delta = 0: count holds. This includes equal up and down counts.
- Read path: read_data = value = {underflow, overflow, count}. It is combinational from the registers.
- Threshold pulse: registered 1 when the previous count < THRESHOLD and the new count ≥ THRESHOLD.
  - Applies to updates from any source except reset.
  - A wrap from high to low does not pulse.

## Timing
- Event to count: 1 cycle. Events sampled at edge N are visible on o_count and read_data after edge N.
- Flags set on the same edge as the offending count update.
- o_threshold_pulse is high for exactly the cycle following the crossing edge; it is never longer than 1 cycle per crossing.
- A register read returns the state as of the current cycle. A read and a write in the same cycle return the pre-write value.
- Reset mid-operation: all state returns to reset values on that edge; pending events are lost.
- All outputs are registered or direct register decodes; no input-to-output combinational path except bit_field_if.read_data.

## Structure
- `rggen_counter_pkg` holds:
  - `counter_mode_e` (COUNTER_WRAP, COUNTER_SATURATE).
  - The flag bit-position localparams OVF_BIT and UDF_BIT, as offsets from WIDTH.
- Sub-module `rggen_popcount` #(WIDTH): combinational ones-count, output width $clog2(WIDTH+1). Instantiated twice, once for up events and once for down events.
- The top level contains the sum/limit logic, count and flag registers, the pulse register and the interface assigns.

## Test plan
- Reset and readback (WIDTH=4, CHANNELS=3, INITIAL_VALUE=2, THRESHOLD=10): hold i_rst_n=0 for 2 edges.
  - Required: o_count=2, flags=0, read_data=6'h02.
  - Asynchronous check: drop i_rst_n between edges → outputs unchanged until the next edge.
- Multi-event accumulate and pulse: i_up=3'b111, i_down=3'b001 for 4 cycles from count=2.
  - Required: count goes 4,6,8,10.
  - o_threshold_pulse=1 only in the cycle after count becomes 10.
- Wrap vs. saturate: count=14, i_up=3'b111.
  - WRAP: count=1, overflow=1.
  - SATURATE: count=15, overflow=1.
  - Mirror case: count=1, i_down=3'b111 gives WRAP 14 or SATURATE 0, underflow=1 in both.
- Priority: same cycle, write count=5 with mask 4'hF, i_clear=1 and i_up=3'b111.
  - Required: count=5.
  - Next cycle with i_clear=1 and i_up=3'b111: count=2, flags unchanged.
- W1C race: overflow=1, software writes 1 to bit WIDTH in the same cycle as a new overflow.
  - Required: overflow stays 1.
  - A following W1C-only cycle clears it to 0.
  - Writing 0 to the flag leaves it at 1.
- Partial mask: count=4'hA, write data 4'h5 with mask 4'h3.
  - Required: count=4'h9.
  - No flag change and no pulse.
